// File: rtl/exe_stage.sv
// ARM execute stage: operand forwarding, Val2 generation, ALU with NZCV flags,
// branch target computation and the EX/MEM pipeline register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        Freeze,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  input  logic        Imm_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic [3:0]  EX_CMD_in,
  input  logic [3:0]  Dest_in,
  input  logic [11:0] shifter_operand_in,
  input  logic [23:0] signed_immediate_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic [1:0]  Sel_src1,
  input  logic [1:0]  Sel_src2,
  input  logic [31:0] MEM_ALU_Res,
  input  logic [31:0] WB_Value,
  output logic        Branch_Taken,
  output logic [31:0] Branch_Address,
  output logic [3:0]  Status_Register,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic        WB_EN_out,
  output logic [31:0] ALU_Res_out,
  output logic [31:0] Val_Rm_out,
  output logic [3:0]  Dest_out
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_t;

  logic [31:0] op1, rm_fwd, val2, imm32, res;
  logic [63:0] imm_rot, rm_rot;
  logic [4:0]  rot_amt, sh_amt;
  logic [32:0] sum;
  logic        cin, flag_c, flag_v, cmd_valid;
  logic [3:0]  nzcv;

  always_comb begin
    unique case (Sel_src1)
      2'b01:   op1 = MEM_ALU_Res;
      2'b10:   op1 = WB_Value;
      default: op1 = Val_Rn_in;
    endcase
    unique case (Sel_src2)
      2'b01:   rm_fwd = MEM_ALU_Res;
      2'b10:   rm_fwd = WB_Value;
      default: rm_fwd = Val_Rm_in;
    endcase
  end

  // Rotations are taken from the low word of a doubled value shifted right.
  always_comb begin
    imm32   = {24'b0, shifter_operand_in[7:0]};
    rot_amt = {shifter_operand_in[11:8], 1'b0};
    imm_rot = {imm32, imm32} >> rot_amt;
    sh_amt  = shifter_operand_in[11:7];
    rm_rot  = {rm_fwd, rm_fwd} >> sh_amt;
    if (Imm_in) begin
      val2 = imm_rot[31:0];
    end else if (MEM_R_EN_in || MEM_W_EN_in) begin
      val2 = {20'b0, shifter_operand_in};
    end else begin
      unique case (shifter_operand_in[6:5])
        2'b00:   val2 = rm_fwd << sh_amt;
        2'b01:   val2 = rm_fwd >> sh_amt;
        2'b10:   val2 = $signed(rm_fwd) >>> sh_amt;
        default: val2 = rm_rot[31:0];
      endcase
    end
  end

  always_comb begin
    cin       = Status_Register[1];
    sum       = '0;
    res       = '0;
    flag_c    = Status_Register[1];
    flag_v    = Status_Register[0];
    cmd_valid = 1'b1;
    case (EX_CMD_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = op1 & val2;
      CMD_ORR: res = op1 | val2;
      CMD_EOR: res = op1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, op1} + {1'b0, val2} + {32'b0, (EX_CMD_in == CMD_ADC) && cin};
        res    = sum[31:0];
        flag_c = sum[32];
        flag_v = (op1[31] == val2[31]) && (res[31] != op1[31]);
      end
      CMD_SUB, CMD_SBC: begin
        // Carry out of op1 + ~val2 + 1 (or + Cin for SBC) is the ARM not-borrow.
        sum    = {1'b0, op1} + {1'b0, ~val2} + {32'b0, (EX_CMD_in == CMD_SUB) || cin};
        res    = sum[31:0];
        flag_c = sum[32];
        flag_v = (op1[31] != val2[31]) && (res[31] != op1[31]);
      end
      default: cmd_valid = 1'b0;
    endcase
    nzcv = {res[31], res == '0, flag_c, flag_v};
  end

  assign Branch_Taken   = B_in;
  assign Branch_Address = PC_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Status_Register <= '0;
      MEM_R_EN_out    <= 1'b0;
      MEM_W_EN_out    <= 1'b0;
      WB_EN_out       <= 1'b0;
      ALU_Res_out     <= '0;
      Val_Rm_out      <= '0;
      Dest_out        <= '0;
    end else if (!Freeze) begin
      if (S_in && cmd_valid) Status_Register <= nzcv;
      MEM_R_EN_out <= MEM_R_EN_in;
      MEM_W_EN_out <= MEM_W_EN_in;
      WB_EN_out    <= WB_EN_in;
      ALU_Res_out  <= res;
      Val_Rm_out   <= rm_fwd;
      Dest_out     <= Dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, Freeze;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Imm_in, B_in, S_in;
  logic [3:0]  EX_CMD_in, Dest_in;
  logic [11:0] shifter_operand_in;
  logic [23:0] signed_immediate_in;
  logic [31:0] PC_in, Val_Rn_in, Val_Rm_in, MEM_ALU_Res, WB_Value;
  logic [1:0]  Sel_src1, Sel_src2;
  logic        Branch_Taken, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out;
  logic [31:0] Branch_Address, ALU_Res_out, Val_Rm_out;
  logic [3:0]  Status_Register, Dest_out;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .Freeze(Freeze),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .Imm_in(Imm_in), .B_in(B_in), .S_in(S_in),
    .EX_CMD_in(EX_CMD_in), .Dest_in(Dest_in),
    .shifter_operand_in(shifter_operand_in), .signed_immediate_in(signed_immediate_in),
    .PC_in(PC_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
    .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
    .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
    .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
    .Status_Register(Status_Register),
    .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out), .WB_EN_out(WB_EN_out),
    .ALU_Res_out(ALU_Res_out), .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one ALU instruction at the falling edge.
  task automatic op(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                    input logic [31:0] rm, input logic [11:0] so, input logic imm);
    @(negedge clk);
    EX_CMD_in = cmd; S_in = s; Val_Rn_in = rn; Val_Rm_in = rm;
    shifter_operand_in = so; Imm_in = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; Freeze = 1'b0;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_EN_in = 1'b0;
    Imm_in = 1'b0; B_in = 1'b0; S_in = 1'b0;
    EX_CMD_in = '0; Dest_in = '0; shifter_operand_in = '0; signed_immediate_in = '0;
    PC_in = '0; Val_Rn_in = '0; Val_Rm_in = '0; Sel_src1 = '0; Sel_src2 = '0;
    MEM_ALU_Res = '0; WB_Value = '0;
    #2;
    chk("reset_status", {28'b0, Status_Register}, 32'h0);
    chk("reset_res", ALU_Res_out, 32'h0);

    // Release, then ADD 3+4 lands one edge later
    op(4'b0010, 1'b0, 32'd3, 32'd4, 12'h000, 1'b0);
    rst = 1'b1; WB_EN_in = 1'b1; Dest_in = 4'd5;
    tick();
    chk("add_res", ALU_Res_out, 32'd7);
    chk("add_dest", {28'b0, Dest_out}, 32'd5);
    chk("add_wb", {31'b0, WB_EN_out}, 32'd1);

    // Mid-cycle reset with Freeze asserted clears at once and stays clear
    @(negedge clk);
    #2 rst = 1'b0; Freeze = 1'b1;
    #1;
    chk("midrst_res", ALU_Res_out, 32'h0);
    chk("midrst_dest", {28'b0, Dest_out}, 32'h0);
    tick();
    chk("rst_freeze_wb", {31'b0, WB_EN_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1; Freeze = 1'b0; WB_EN_in = 1'b0; Dest_in = 4'd0;

    op(4'b0010, 1'b1, 32'h7FFFFFFF, 32'd1, 12'h000, 1'b0); tick();
    chk("add_ovf_res", ALU_Res_out, 32'h80000000);
    chk("add_ovf_nzcv", {28'b0, Status_Register}, 32'b1001);
    op(4'b0011, 1'b1, 32'd0, 32'd0, 12'h000, 1'b0); tick();
    chk("adc_c0_res", ALU_Res_out, 32'd0);
    chk("adc_c0_nzcv", {28'b0, Status_Register}, 32'b0100);

    op(4'b0100, 1'b1, 32'd5, 32'd5, 12'h000, 1'b0); tick();
    chk("sub_res", ALU_Res_out, 32'd0);
    chk("sub_nzcv", {28'b0, Status_Register}, 32'b0110);
    op(4'b0101, 1'b0, 32'd5, 32'd3, 12'h000, 1'b0); tick();
    chk("sbc_c1_res", ALU_Res_out, 32'd2);
    chk("s0_keeps_nzcv", {28'b0, Status_Register}, 32'b0110);
    op(4'b0010, 1'b1, 32'd1, 32'd1, 12'h000, 1'b0); tick();
    chk("clear_c_nzcv", {28'b0, Status_Register}, 32'b0000);
    op(4'b0101, 1'b1, 32'd5, 32'd3, 12'h000, 1'b0); tick();
    chk("sbc_c0_res", ALU_Res_out, 32'd1);
    chk("sbc_c0_nzcv", {28'b0, Status_Register}, 32'b0010);

    // MOV immediate: logical op keeps C and V
    op(4'b0001, 1'b1, 32'd0, 32'd0, 12'h4FF, 1'b1); tick();
    chk("imm_rot", ALU_Res_out, 32'hFF000000);
    chk("mov_nzcv", {28'b0, Status_Register}, 32'b1010);
    op(4'b0001, 1'b0, 32'd0, 32'h80000000, 12'h240, 1'b0); tick();
    chk("asr4", ALU_Res_out, 32'hF8000000);
    op(4'b1001, 1'b0, 32'd0, 32'h0000FFFF, 12'h000, 1'b0); tick();
    chk("mvn", ALU_Res_out, 32'hFFFF0000);

    op(4'b0010, 1'b0, 32'h1000, 32'hCAFE0001, 12'hFFC, 1'b0);
    MEM_W_EN_in = 1'b1;
    tick();
    chk("str_addr", ALU_Res_out, 32'h00001FFC);
    chk("str_data", Val_Rm_out, 32'hCAFE0001);
    chk("str_wen", {31'b0, MEM_W_EN_out}, 32'd1);

    op(4'b0010, 1'b0, 32'h99, 32'd1, 12'h000, 1'b0);
    MEM_W_EN_in = 1'b0; Sel_src1 = 2'b01; MEM_ALU_Res = 32'h10;
    tick();
    chk("fwd_src1_mem", ALU_Res_out, 32'h11);
    op(4'b0001, 1'b0, 32'h0, 32'h77, 12'h000, 1'b0);
    Sel_src1 = 2'b00; Sel_src2 = 2'b10; WB_Value = 32'h20; Dest_in = 4'd9;
    tick();
    chk("fwd_src2_wb", ALU_Res_out, 32'h20);
    chk("fwd_store_data", Val_Rm_out, 32'h20);

    // Freeze across two edges with flag-setting, changing inputs
    op(4'b0100, 1'b1, 32'd5, 32'd5, 12'h000, 1'b0);
    Freeze = 1'b1; Sel_src2 = 2'b00; Dest_in = 4'd3; WB_EN_in = 1'b1;
    tick();
    op(4'b0010, 1'b1, 32'h7FFFFFFF, 32'd1, 12'h000, 1'b0);
    tick();
    chk("freeze_res", ALU_Res_out, 32'h20);
    chk("freeze_nzcv", {28'b0, Status_Register}, 32'b1010);
    chk("freeze_dest", {28'b0, Dest_out}, 32'd9);
    chk("freeze_wb", {31'b0, WB_EN_out}, 32'd0);

    op(4'b0000, 1'b1, 32'd5, 32'd3, 12'h000, 1'b0);
    Freeze = 1'b0;
    tick();
    chk("bad_cmd_res", ALU_Res_out, 32'd0);
    chk("bad_cmd_nzcv", {28'b0, Status_Register}, 32'b1010);

    @(negedge clk);
    B_in = 1'b1; PC_in = 32'h100; signed_immediate_in = 24'hFFFFFE;
    #1;
    chk("br_taken", {31'b0, Branch_Taken}, 32'd1);
    chk("br_addr_back", Branch_Address, 32'h000000F8);
    signed_immediate_in = 24'h000010;
    #1;
    chk("br_addr_fwd", Branch_Address, 32'h00000140);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
